// File: rtl/fetch_align.sv
// Instruction fetch aligner: issues word fetches, queues halfwords, and presents
// each instruction as one 32-bit parcel with its PC. Optional counters under FETCH_ALIGN_PERF_EN.
module fetch_align #(
    parameter int unsigned       XLEN            = 64,
    parameter logic [XLEN-1:0]   RESET_PC        = '0,
    parameter int unsigned       MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [31:0]     rsp_data,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr_data,
    output logic [XLEN-1:0] instr_pc
`ifdef FETCH_ALIGN_PERF_EN
    ,
    output logic [31:0]     perf_c_cnt,
    output logic [31:0]     perf_i_cnt
`endif
);

    localparam int unsigned QDEPTH  = 6;
    localparam logic [1:0]  MAX_OUT = 2'(MAX_OUTSTANDING);

    logic [15:0]     q_q [QDEPTH];
    logic [15:0]     q_d [QDEPTH];
    logic [15:0]     ext [8];
    logic [2:0]      cnt_q, cnt_d;
    logic [1:0]      out_q, out_d;
    logic [1:0]      drop_q, drop_d;
    logic            skip_q, skip_d;
    logic            run_q;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] pc_q, pc_d;

    logic [15:0]     head_hw, next_hw;
    logic            is_c;
    logic [3:0]      occ;
    logic            req_fire, consume;
    logic [1:0]      pop_n, push_n;
    logic            rsp_keep;
    logic [15:0]     push_lo, push_hi;
    logic [2:0]      base;
    logic [3:0]      cnt_sum;
    logic [2:0]      sidx;
    logic            unused_flush_lsb;

    assign unused_flush_lsb = flush_pc[0];

    assign head_hw    = (cnt_q != 3'd0) ? q_q[0] : 16'h0;
    assign next_hw    = (cnt_q >= 3'd2) ? q_q[1] : 16'h0;
    assign is_c       = (head_hw[1:0] != 2'b11);
    assign instr_data = {next_hw, head_hw};
    assign instr_pc   = pc_q;
    assign req_addr   = addr_q;

    // Outstanding requests reserve two queue slots each so responses can never overflow.
    assign occ         = {1'b0, cnt_q} + {1'b0, out_q, 1'b0};
    assign req_valid   = run_q && !flush && (out_q < MAX_OUT) && (occ <= 4'd4);
    assign instr_valid = !flush && ((cnt_q >= 3'd2) || ((cnt_q == 3'd1) && is_c));

    assign req_fire = req_valid && req_ready;
    assign consume  = instr_valid && instr_ready;
    assign pop_n    = !consume ? 2'd0 : (is_c ? 2'd1 : 2'd2);

    assign rsp_keep = rsp_valid && (drop_q == 2'd0);
    assign push_n   = !rsp_keep ? 2'd0 : (skip_q ? 2'd1 : 2'd2);
    assign push_lo  = skip_q ? rsp_data[31:16] : rsp_data[15:0];
    assign push_hi  = rsp_data[31:16];

    assign base    = cnt_q - {1'b0, pop_n};
    assign cnt_sum = {1'b0, base} + {2'b00, push_n};

    always_comb begin
        sidx = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            ext[i] = q_q[i];
        end
        ext[6] = '0;
        ext[7] = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            sidx   = 3'(i) + {1'b0, pop_n};
            q_d[i] = (sidx < cnt_q) ? ext[sidx] : 16'h0;
            if ((push_n != 2'd0) && (3'(i) == base)) begin
                q_d[i] = push_lo;
            end
            if ((push_n == 2'd2) && (3'(i) == base + 3'd1)) begin
                q_d[i] = push_hi;
            end
        end
    end

    always_comb begin
        cnt_d  = cnt_sum[2:0];
        out_d  = out_q + {1'b0, req_fire} - {1'b0, rsp_valid};
        drop_d = drop_q;
        skip_d = skip_q;
        addr_d = addr_q;
        pc_d   = pc_q;
        if (flush) begin
            // Every request still in flight is stale; that count already includes earlier stale ones.
            cnt_d  = 3'd0;
            drop_d = out_q - {1'b0, rsp_valid};
            skip_d = flush_pc[1];
            addr_d = {flush_pc[XLEN-1:2], 2'b00};
            pc_d   = {flush_pc[XLEN-1:1], 1'b0};
        end else begin
            if (rsp_valid && (drop_q != 2'd0)) begin
                drop_d = drop_q - 2'd1;
            end
            if (rsp_keep && skip_q) begin
                skip_d = 1'b0;
            end
            if (req_fire) begin
                addr_d = addr_q + XLEN'(4);
            end
            if (consume) begin
                pc_d = pc_q + (is_c ? XLEN'(2) : XLEN'(4));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 3'd0;
            out_q  <= 2'd0;
            drop_q <= 2'd0;
            skip_q <= RESET_PC[1];
            run_q  <= 1'b0;
            addr_q <= {RESET_PC[XLEN-1:2], 2'b00};
            pc_q   <= RESET_PC;
        end else begin
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            drop_q <= drop_d;
            skip_q <= skip_d;
            run_q  <= 1'b1;
            addr_q <= addr_d;
            pc_q   <= pc_d;
        end
    end

    // Queue storage carries no reset; occupancy is tracked by cnt_q alone.
    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

`ifdef FETCH_ALIGN_PERF_EN
    logic [31:0] perf_c_q, perf_i_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_c_q <= 32'd0;
            perf_i_q <= 32'd0;
        end else if (consume) begin
            if (is_c) begin
                perf_c_q <= perf_c_q + 32'd1;
            end else begin
                perf_i_q <= perf_i_q + 32'd1;
            end
        end
    end

    assign perf_c_cnt = perf_c_q;
    assign perf_i_cnt = perf_i_q;
`endif

    a_rsp_without_request: assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp_valid && (out_q == 2'd0)));

    a_queue_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        flush || (cnt_sum <= 4'd6));

endmodule
